// File: rtl/commit_ctrl_pkg.sv
// Shared widths and FSM encoding for the in-order retirement sequencer.
// Imported by commit_ctrl_if and commit_ctrl.
package commit_ctrl_pkg;

  localparam int DATA_WID    = 32;
  localparam int REG_POS_WID = 5;
  localparam int ROB_POS_WID = 4;
  localparam int ROB_ID_WID  = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RECOVER = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

endpackage

// File: rtl/commit_ctrl_if.sv
// ROB-head / RegFile-commit bundle between the ReorderBuffer and commit_ctrl.
// master = ROB / pipeline side, slave = commit_ctrl.
interface commit_ctrl_if
  import commit_ctrl_pkg::*;
#(
  parameter int ROB_POS_W = ROB_POS_WID,
  parameter int REG_POS_W = REG_POS_WID,
  parameter int DATA_W    = DATA_WID
) ();

  logic                 head_valid;
  logic                 head_ready;
  logic                 head_has_rd;
  logic [REG_POS_W-1:0] head_rd;
  logic [DATA_W-1:0]    head_val;
  logic [ROB_POS_W-1:0] head_rob_pos;
  logic                 head_mispred;
  logic [DATA_W-1:0]    head_target_pc;
  logic                 head_is_halt;

  logic                 rob_pop;
  logic                 commit;
  logic [REG_POS_W-1:0] commit_rd;
  logic [DATA_W-1:0]    commit_val;
  logic [ROB_POS_W-1:0] commit_rob_pos;
  logic                 flush;
  logic [DATA_W-1:0]    flush_pc;
  logic                 halted;

  modport master (
    output head_valid, head_ready, head_has_rd, head_rd, head_val,
           head_rob_pos, head_mispred, head_target_pc, head_is_halt,
    input  rob_pop, commit, commit_rd, commit_val, commit_rob_pos,
           flush, flush_pc, halted
  );

  modport slave (
    input  head_valid, head_ready, head_has_rd, head_rd, head_val,
           head_rob_pos, head_mispred, head_target_pc, head_is_halt,
    output rob_pop, commit, commit_rd, commit_val, commit_rob_pos,
           flush, flush_pc, halted
  );

endinterface

// File: rtl/commit_ctrl.sv
// In-order retirement sequencer: pops the ROB head, drives the RegFile commit
// port, raises flush on mispredict and latches halt. Optional counters: COMMIT_STATS_EN.
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int ROB_POS_W = ROB_POS_WID,
  parameter int REG_POS_W = REG_POS_WID,
  parameter int DATA_W    = DATA_WID
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  commit_ctrl_if.slave  bus
`ifdef COMMIT_STATS_EN
  ,
  output logic [31:0]   retire_cnt,
  output logic [31:0]   mispred_cnt
`endif
);

  state_t               state_r;
  state_t               next_state_s;
  logic                 pop_s;
  logic                 wr_s;
  logic                 flush_set_s;
  logic                 halt_set_s;

  logic                 commit_r;
  logic [REG_POS_W-1:0] commit_rd_r;
  logic [DATA_W-1:0]    commit_val_r;
  logic [ROB_POS_W-1:0] commit_rob_pos_r;
  logic                 flush_r;
  logic [DATA_W-1:0]    flush_pc_r;
  logic                 halted_r;

  // Pop decision and next state; RECOVER waits until the flush pulse has dropped.
  always_comb begin
    pop_s        = 1'b0;
    next_state_s = state_r;
    case (state_r)
      ST_RUN: begin
        pop_s = rdy & bus.head_valid & bus.head_ready;
        if (pop_s && bus.head_is_halt) begin
          next_state_s = ST_HALT;
        end else if (pop_s && bus.head_mispred) begin
          next_state_s = ST_RECOVER;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_RECOVER: begin
        if (flush_r) begin
          next_state_s = ST_RECOVER;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_HALT: begin
        next_state_s = ST_HALT;
      end
      default: begin
        next_state_s = ST_RUN;
      end
    endcase
  end

  // Retirement side effects of a pop; halt wins over mispredict.
  always_comb begin
    wr_s        = pop_s & bus.head_has_rd & (bus.head_rd != {REG_POS_W{1'b0}});
    halt_set_s  = pop_s & bus.head_is_halt;
    flush_set_s = pop_s & bus.head_mispred & ~bus.head_is_halt;
  end

  // State and registered commit/flush/halt outputs; everything freezes while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_RUN;
      commit_r         <= 1'b0;
      commit_rd_r      <= {REG_POS_W{1'b0}};
      commit_val_r     <= {DATA_W{1'b0}};
      commit_rob_pos_r <= {ROB_POS_W{1'b0}};
      flush_r          <= 1'b0;
      flush_pc_r       <= {DATA_W{1'b0}};
      halted_r         <= 1'b0;
    end else if (rdy) begin
      state_r  <= next_state_s;
      commit_r <= wr_s;
      flush_r  <= flush_set_s;
      halted_r <= halted_r | halt_set_s;
      if (pop_s) begin
        commit_rd_r      <= bus.head_rd;
        commit_val_r     <= bus.head_val;
        commit_rob_pos_r <= bus.head_rob_pos;
      end
      if (flush_set_s) begin
        flush_pc_r <= bus.head_target_pc;
      end
    end
  end

  assign bus.rob_pop        = pop_s;
  assign bus.commit         = commit_r;
  assign bus.commit_rd      = commit_rd_r;
  assign bus.commit_val     = commit_val_r;
  assign bus.commit_rob_pos = commit_rob_pos_r;
  assign bus.flush          = flush_r;
  assign bus.flush_pc       = flush_pc_r;
  assign bus.halted         = halted_r;

`ifdef COMMIT_STATS_EN
  logic [31:0] retire_cnt_r;
  logic [31:0] mispred_cnt_r;

  // Retire/mispredict counters; pops never happen in HALT, so they freeze there.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_r  <= 32'd0;
      mispred_cnt_r <= 32'd0;
    end else if (rdy && pop_s) begin
      retire_cnt_r <= retire_cnt_r + 32'd1;
      if (bus.head_mispred) begin
        mispred_cnt_r <= mispred_cnt_r + 32'd1;
      end
    end
  end

  assign retire_cnt  = retire_cnt_r;
  assign mispred_cnt = mispred_cnt_r;
`endif

endmodule
